// File: rtl/demux_1_4_tdm_s4.sv
// ============================================================================
// Module   : demux_1_4_tdm_s4
// Purpose  : 4-slot TDM lane de-interleaver with sync-aligned frame counter.
//            Optional macro DEMUX_ERR_STICKY_EN makes err hold until reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_1_4_tdm_s4 #(
  parameter int CHANNELS = 4,
  parameter int W        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync,
  input  logic [W-1:0]          in,
  output logic [1:0]            sel,
  output logic [CHANNELS*W-1:0] out,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int              SEL_W     = 2;
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  // Slots 0..CHANNELS-2 wait here; the last slot goes straight to out.
  logic [(CHANNELS-1)*W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
`ifdef DEMUX_ERR_STICKY_EN
      err         <= err;
`else
      err         <= 1'b0;
`endif
      if (en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              shadow[W-1:0] <= in;
              sel           <= 2'd1;
              state         <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // An early sync drops the partial frame and restarts at slot 0.
              if (sel != 2'd0) begin
                err <= 1'b1;
              end
              shadow[W-1:0] <= in;
              sel           <= 2'd1;
            end else if (sel == 2'd0) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (sel == LAST_SLOT) begin
              out         <= {in, shadow};
              frame_valid <= 1'b1;
              sel         <= 2'd0;
            end else begin
              for (int k = 1; k < CHANNELS - 1; k++) begin
                if (sel == SEL_W'(k)) begin
                  shadow[k*W +: W] <= in;
                end
              end
              sel <= sel + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
            sel   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/demux_1_4_tdm_s4.md
Name: demux_1_4_tdm_S4

Overview:
Receive side of the 4:1 enabled multiplexer path. The block takes a time-division-multiplexed stream on a single lane, tracks the slot index with a frame counter aligned by a sync strobe, and de-interleaves successive slots into four channel registers. A complete 4-slot frame is published on a parallel output together with a one-cycle valid pulse. It sits directly downstream of the mux on the same board-level lane.

Parameters:
- CHANNELS, 4, number of TDM slots per frame; fixed at 4 in this revision; SEL_W = 2.
- W, 1, bits per slot (lane width).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  slot strobe; a slot is consumed only on a clock edge where en=1.
- sync  input  1  frame-start marker; qualified by en; marks the current slot as slot 0.
- in  input  W  lane data for the current slot.
- sel  output  2  index of the slot the next en-qualified edge will capture.
- out  output  CHANNELS*W  last complete frame; channel k occupies out[k*W +: W].
- frame_valid  output  1  one-cycle pulse when out is updated.
- err  output  1  framing error indication.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; sel=0; shadow registers=0; out=0; frame_valid=0; err=0. Reset may assert at any cycle and aborts any partial frame. No out update occurs for a partial frame.
- FSM has two states, IDLE and RUN.
- IDLE:
  - en=1 & sync=1: capture in into shadow[0]; sel<=1; go to RUN.
  - en=1 & sync=0: data ignored; sel stays 0; no error.
  - en=0: hold all state.
- RUN, on an en=1 edge with sync=0:
  - Capture in into shadow[sel].
  - If sel<3: sel<=sel+1.
  - If sel==3: out<={in, shadow[2], shadow[1], shadow[0]}; frame_valid<=1; sel wraps to 0; stay in RUN.
  - The next frame then expects sync on the slot-0 edge.
- RUN, on an en=1 edge with sync=1:
  - sel==0: normal frame start; capture shadow[0]; sel<=1.
  - sel!=0 (early sync): err asserts for 1 cycle; the partial frame is discarded (out unchanged, no frame_valid); the current in is captured as slot 0; sel<=1. The block resynchronises.
- RUN, on an en=1 edge with sel==0 and sync=0 (missing sync):
  - err asserts for 1 cycle; data is dropped; go to IDLE; sel=0.
- en=0 in RUN: stall. sel, shadow, and out hold; frame_valid=0; gaps of any length are legal mid-frame.
- Latency: out and frame_valid are registered together at the edge capturing slot 3. They are visible 1 clk after that edge's sample, and frame_valid stays high exactly one cycle.
- out holds its value between frames and across IDLE. Only a complete frame or reset changes it.
- Back-to-back frames (en held high, sync every 4th cycle): frame_valid pulses every 4 cycles with no bubble.
- Widths: sel wraps modulo 4. No arithmetic beyond the 2-bit increment.

Optional Feature:
- Macro: DEMUX_ERR_STICKY_EN.
- Defined: err is sticky. It is set on any framing error (early or missing sync) and cleared only by rst_n=0. Frame processing continues unaffected.
- Undefined: err is a single-cycle pulse per error event, as described in Behaviour.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle during RUN with sel=2 -> immediately sel=0, out=0, frame_valid=0, err=0; the partial frame is never published after release.
- Single frame: en=1 continuously; slots in=1,0,1,0 with sync on the first -> at the 4th edge out=4'b0101 (ch0=1, ch1=0, ch2=1, ch3=0); frame_valid high for exactly 1 cycle.
- Stall: same frame with en=0 for 3 cycles between slots 1 and 2 -> identical out=4'b0101; sel holds at 2 during the stall; no spurious frame_valid.
- Early sync: after slots in=1,1 (sel=2), apply sync with in=0 -> err pulse (1 cycle), out unchanged. Continue with in=1,1,0 -> out=4'b0110, frame_valid once.
- Missing sync: after a full frame, apply en=1, sync=0 at sel=0 -> err pulse, state IDLE. Further en without sync -> no change until sync. With DEMUX_ERR_STICKY_EN, err stays 1 until reset.
- Back-to-back: 3 consecutive frames 0xA, 0x5, 0xF with en always high -> frame_valid at cycles 4, 8, 12 with out=4'b1010, 4'b0101, 4'b1111 respectively.
